// File: rtl/win_screen_ctrl_if.sv
// Pixel-path bundle for win_screen_ctrl: raster position/background in, sprite ROM
// address/data, composited pixel out. Streaming bus with no handshake: one pixel per clock.
interface win_screen_ctrl_if;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic [15:0] bg_rgb;
  logic [5:0]  rom_x;
  logic [5:0]  rom_y;
  logic [15:0] rom_rgb;
  logic [15:0] rgb_out;

  modport master (
    output hcount, vcount, video_on, bg_rgb, rom_rgb,
    input  rom_x, rom_y, rgb_out
  );

  modport slave (
    input  hcount, vcount, video_on, bg_rgb, rom_rgb,
    output rom_x, rom_y, rgb_out
  );
endinterface

// File: rtl/win_screen_ctrl.sv
// "You win" overlay: IDLE/SHOW/HOLD sequencer plus 3-stage sprite compositing pipeline.
// Optional macro WIN_SCREEN_BLINK_EN blinks the text band (rom_y <= 20) during SHOW.
module win_screen_ctrl #(
  parameter logic [9:0] ORIGIN_X     = 10'd256,
  parameter logic [9:0] ORIGIN_Y     = 10'd192,
  parameter int         SCALE_LOG2   = 1,
  parameter logic [7:0] SHOW_FRAMES  = 8'd180,
  parameter logic [7:0] BLINK_FRAMES = 8'd15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 win_evt,
  input  logic                 restart,
  input  logic                 frame_tick,
  win_screen_ctrl_if.slave     pix,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [10:0] X_LO = {1'b0, ORIGIN_X};
  localparam logic [10:0] X_HI = X_LO + 11'(64 << SCALE_LOG2);
  localparam logic [10:0] Y_LO = {1'b0, ORIGIN_Y};
  localparam logic [10:0] Y_HI = Y_LO + 11'(48 << SCALE_LOG2);

  state_t     state, state_nx;
  logic       enter_show;
  logic [7:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // restart has priority over everything, including a coincident win_evt
  always_comb begin
    state_nx   = state;
    enter_show = 1'b0;
    if (restart) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (win_evt) begin
          state_nx   = S_SHOW;
          enter_show = 1'b1;
        end
        S_SHOW: if (frame_tick && frame_cnt == SHOW_FRAMES - 8'd1) state_nx = S_HOLD;
        S_HOLD: state_nx = S_HOLD;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst)                                frame_cnt <= 8'd0;
    else if (enter_show)                    frame_cnt <= 8'd0;
    else if (state == S_SHOW && frame_tick) frame_cnt <= frame_cnt + 8'd1;
  end

`ifdef WIN_SCREEN_BLINK_EN
  logic       blink;
  logic [7:0] blink_cnt;
  logic       hide_d1, hide_d2;
  logic [5:0] rom_y_d2;

  always_ff @(posedge clk) begin
    if (rst || enter_show) begin
      blink     <= 1'b1;
      blink_cnt <= 8'd0;
    end else if (state == S_SHOW && frame_tick) begin
      if (blink_cnt == BLINK_FRAMES - 8'd1) begin
        blink_cnt <= 8'd0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end else if (state == S_HOLD) begin
      blink <= 1'b1;
    end
  end
`endif

  logic [10:0] h_ext, v_ext;
  logic        in_win_c;
  logic [5:0]  rom_x_c, rom_y_c;

  assign h_ext    = {1'b0, pix.hcount};
  assign v_ext    = {1'b0, pix.vcount};
  assign in_win_c = (h_ext >= X_LO) && (h_ext < X_HI) && (v_ext >= Y_LO) && (v_ext < Y_HI);
  assign rom_x_c  = 6'((pix.hcount - ORIGIN_X) >> SCALE_LOG2);
  assign rom_y_c  = 6'((pix.vcount - ORIGIN_Y) >> SCALE_LOG2);

  // State is sampled alongside the pixel so a transition never splits one pixel
  logic        in_win_d1, von_d1, show_d1;
  logic [15:0] bg_d1;
  logic        in_win_d2, von_d2, show_d2;
  logic [15:0] bg_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix.rom_x <= 6'd0;
      pix.rom_y <= 6'd0;
      in_win_d1 <= 1'b0;
      von_d1    <= 1'b0;
      show_d1   <= 1'b0;
      bg_d1     <= 16'h0000;
      in_win_d2 <= 1'b0;
      von_d2    <= 1'b0;
      show_d2   <= 1'b0;
      bg_d2     <= 16'h0000;
    end else begin
      pix.rom_x <= in_win_c ? rom_x_c : 6'd0;
      pix.rom_y <= in_win_c ? rom_y_c : 6'd0;
      in_win_d1 <= in_win_c;
      von_d1    <= pix.video_on;
      show_d1   <= (state != S_IDLE);
      bg_d1     <= pix.bg_rgb;
      in_win_d2 <= in_win_d1;
      von_d2    <= von_d1;
      show_d2   <= show_d1;
      bg_d2     <= bg_d1;
    end
  end

  logic text_hide;
`ifdef WIN_SCREEN_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hide_d1  <= 1'b0;
      hide_d2  <= 1'b0;
      rom_y_d2 <= 6'd0;
    end else begin
      hide_d1  <= (state == S_SHOW) && !blink;
      hide_d2  <= hide_d1;
      rom_y_d2 <= pix.rom_y;
    end
  end
  assign text_hide = hide_d2 && (rom_y_d2 <= 6'd20);
`else
  assign text_hide = 1'b0;
`endif

  logic [15:0] rgb_c;
  always_comb begin
    rgb_c = 16'h0000;
    if (!von_d2)
      rgb_c = 16'h0000;
    else if (!show_d2 || !in_win_d2 || pix.rom_rgb == 16'h0000 || text_hide)
      rgb_c = bg_d2;
    else
      rgb_c = pix.rom_rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) pix.rgb_out <= 16'h0000;
    else     pix.rgb_out <= rgb_c;
  end

endmodule

// File: tb/tb_win_screen_ctrl.sv
// Directed scoreboard bench for win_screen_ctrl: drivers queue expected pixels,
// a negedge monitor compares rgb_out three clocks after each checked input.
module tb_win_screen_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       win_evt = 1'b0;
  logic       restart = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] state_o;

  win_screen_ctrl_if pix ();

  win_screen_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .win_evt    (win_evt),
    .restart    (restart),
    .frame_tick (frame_tick),
    .pix        (pix.slave),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic        chk_in = 1'b0;
  logic [2:0]  chk_pipe = 3'b000;
  logic [15:0] exp_v;

  // Sprite ROM: column 1 solid green, column 5 transparent, elsewhere {y,x,4'hA}
  function automatic logic [15:0] rom_model(input logic [5:0] x, input logic [5:0] y);
    if (x == 6'd1)      return 16'h07E0;
    else if (x == 6'd5) return 16'h0000;
    else                return {y, x, 4'hA};
  endfunction

  always @(posedge clk) begin
    pix.rom_rgb <= rom_model(pix.rom_x, pix.rom_y);
    chk_pipe    <= {chk_pipe[1:0], chk_in};
  end

  always @(negedge clk) begin
    if (chk_pipe[2]) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rgb_out: got %h with nothing expected", pix.rgb_out);
      end else begin
        exp_v = exp_q.pop_front();
        if (pix.rgb_out !== exp_v) begin
          failures++;
          $display("FAIL rgb_out: got %h expected %h", pix.rgb_out, exp_v);
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_px(input logic [9:0] h, input logic [9:0] v, input logic von,
                          input logic [15:0] bg, input logic [15:0] exp);
    pix.hcount   = h;
    pix.vcount   = v;
    pix.video_on = von;
    pix.bg_rgb   = bg;
    chk_in       = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    chk_in       = 1'b0;
    pix.hcount   = 10'd0;
    pix.vcount   = 10'd0;
    pix.video_on = 1'b0;
    pix.bg_rgb   = 16'h0000;
  endtask

  task automatic pulse_ctrl(input logic w, input logic r);
    win_evt = w;
    restart = r;
    @(posedge clk); #1;
    win_evt = 1'b0;
    restart = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || chk_pipe != 3'b000) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL drain: %0d expected pixels never produced", exp_q.size());
    end
  endtask

  initial begin
    pix.hcount   = 10'd0;
    pix.vcount   = 10'd0;
    pix.video_on = 1'b0;
    pix.bg_rgb   = 16'h0000;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset state_o", 16'(state_o), 16'd0);
    check_val("reset rgb_out", pix.rgb_out, 16'h0000);
    check_val("reset rom_x", 16'(pix.rom_x), 16'd0);
    check_val("reset rom_y", 16'(pix.rom_y), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // IDLE: background only, even inside the window
    drive_px(10'd0,   10'd0,   1'b1, 16'h1234, 16'h1234);
    drive_px(10'd258, 10'd196, 1'b1, 16'h5555, 16'h5555);

    pulse_ctrl(1'b1, 1'b1);
    check_val("win+restart in idle", 16'(state_o), 16'd0);
    pulse_ctrl(1'b1, 1'b0);
    check_val("win -> show", 16'(state_o), 16'd1);

    // Mapping, transparency and window edges in SHOW
    drive_px(10'd258, 10'd196, 1'b1, 16'h1111, 16'h07E0);
    check_val("map rom_x", 16'(pix.rom_x), 16'd1);
    check_val("map rom_y", 16'(pix.rom_y), 16'd2);
    drive_px(10'd266, 10'd196, 1'b1, 16'h2222, 16'h2222);
    drive_px(10'd262, 10'd212, 1'b1, 16'h2323, 16'h283A);
    drive_px(10'd383, 10'd287, 1'b1, 16'h2424, 16'hBFFA);
    drive_px(10'd384, 10'd196, 1'b1, 16'h2525, 16'h2525);
    drive_px(10'd255, 10'd196, 1'b1, 16'h2626, 16'h2626);
    drive_px(10'd258, 10'd288, 1'b1, 16'h2727, 16'h2727);
    drive_px(10'd258, 10'd196, 1'b0, 16'h2828, 16'h0000);

    pulse_ctrl(1'b1, 1'b0);
    check_val("win ignored in show", 16'(state_o), 16'd1);

    // Blink phases: text row y=5, non-text row y=21
    ticks(15);
`ifdef WIN_SCREEN_BLINK_EN
    drive_px(10'd258, 10'd202, 1'b1, 16'h3333, 16'h3333);
`else
    drive_px(10'd258, 10'd202, 1'b1, 16'h3333, 16'h07E0);
`endif
    drive_px(10'd258, 10'd234, 1'b1, 16'h3434, 16'h07E0);
    ticks(15);
    drive_px(10'd258, 10'd202, 1'b1, 16'h3535, 16'h07E0);

    ticks(149);
    check_val("show after 179 ticks", 16'(state_o), 16'd1);
    ticks(1);
    check_val("hold after 180 ticks", 16'(state_o), 16'd2);

    pulse_ctrl(1'b1, 1'b0);
    check_val("win ignored in hold", 16'(state_o), 16'd2);
    drive_px(10'd258, 10'd196, 1'b1, 16'h3636, 16'h07E0);
    pulse_ctrl(1'b0, 1'b1);
    check_val("restart from hold", 16'(state_o), 16'd0);
    drive_px(10'd258, 10'd196, 1'b1, 16'h3737, 16'h3737);

    pulse_ctrl(1'b1, 1'b0);
    check_val("win again", 16'(state_o), 16'd1);
    pulse_ctrl(1'b0, 1'b1);
    check_val("restart from show", 16'(state_o), 16'd0);

    // Reset in the middle of SHOW
    pulse_ctrl(1'b1, 1'b0);
    ticks(3);
    wait_drain();
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst mid-show state", 16'(state_o), 16'd0);
    check_val("rst mid-show rgb_out", pix.rgb_out, 16'h0000);
    rst = 1'b0;
    drive_px(10'd258, 10'd196, 1'b1, 16'h4444, 16'h4444);

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/win_screen_ctrl.md
WIN_SCREEN_CTRL -- requirements
Module: win_screen_ctrl

Interface
REQ-001 Parameter ORIGIN_X, default 10'd256: screen column of the overlay window's left edge.
REQ-002 Parameter ORIGIN_Y, default 10'd192: screen row of the overlay window's top edge.
REQ-003 Parameter SCALE_LOG2, default 1: pixel replication, 0 = 1x or 1 = 2x; window size is (64<<SCALE_LOG2) x (48<<SCALE_LOG2).
REQ-004 Parameter SHOW_FRAMES, default 8'd180: frames spent in SHOW before HOLD.
REQ-005 Parameter BLINK_FRAMES, default 8'd15: frames per blink half-period.
REQ-006 clk  input  1  system clock; the block has one clock, and every flop is on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 win_evt  input  1  single-cycle pulse: the player has won.
REQ-009 restart  input  1  single-cycle pulse: return to IDLE.
REQ-010 frame_tick  input  1  single-cycle pulse, once per frame, during vertical blanking.
REQ-011 hcount  input  10  current screen column.
REQ-012 vcount  input  10  current screen row.
REQ-013 video_on  input  1  high while the screen is in the active display area.
REQ-014 bg_rgb  input  16  RGB565 background pixel for (hcount, vcount).
REQ-015 rom_x  output  6  sprite ROM column address.
REQ-016 rom_y  output  6  sprite ROM row address.
REQ-017 rom_rgb  input  16  sprite ROM pixel data; valid one clock after rom_x/rom_y.
REQ-018 rgb_out  output  16  composited RGB565 pixel.
REQ-019 state_o  output  2  current state: IDLE=0, SHOW=1, HOLD=2.

Function
REQ-020 States:
- IDLE -> SHOW on win_evt.
- SHOW -> HOLD when the frame counter reaches SHOW_FRAMES-1 and frame_tick is high.
- HOLD -> IDLE only on restart.
REQ-021 restart forces IDLE from any state.
REQ-022 If restart and win_evt occur in the same cycle, restart wins.
REQ-023 win_evt is ignored in SHOW and in HOLD.
REQ-024 Frame counter: 8-bit; cleared on entry to SHOW; increments on frame_tick while in SHOW.
REQ-025 Blink phase: a flop, set to 1 on entry to SHOW; it toggles every BLINK_FRAMES frame_ticks during SHOW and is held at 1 in HOLD.
REQ-026 in_win is true when ORIGIN_X <= hcount < ORIGIN_X+(64<<SCALE_LOG2) and ORIGIN_Y <= vcount < ORIGIN_Y+(48<<SCALE_LOG2).
REQ-027 Stage 1 (registered):
- rom_x = (hcount-ORIGIN_X)>>SCALE_LOG2 and rom_y = (vcount-ORIGIN_Y)>>SCALE_LOG2, both truncated to 6 bits.
- Outside the window, rom_x/rom_y hold 0.
REQ-028 Stage 2: the ROM registers rom_rgb.
REQ-029 in_win, video_on, bg_rgb and rom_y are delayed in matching shift stages so they stay aligned with rom_rgb.
REQ-030 Stage 3: rgb_out is registered, giving a total latency of exactly 3 clocks from hcount/vcount to rgb_out.
REQ-031 Compositing, evaluated on the aligned signals:
- If video_on is 0, rgb_out = 16'h0000.
- Otherwise, if the state is IDLE, or in_win is 0, or rom_rgb == 16'h0000, rgb_out = bg_rgb.
- Otherwise, rgb_out = rom_rgb.
REQ-032 State changes take effect on pixels whose hcount/vcount are sampled after the transition; no partial-pixel glitch is allowed.

Reset
REQ-033 On rst, the following are cleared:
- state = IDLE, so state_o = 0.
- Frame counter = 0 and blink phase = 1.
- rom_x = 0 and rom_y = 0.
- rgb_out = 16'h0000 and all pipeline stages = 0.
REQ-034 rst asserted mid-SHOW or mid-HOLD returns the block to IDLE on the next edge; the first rgb_out after reset is 0.

Configuration
REQ-035 Macro WIN_SCREEN_BLINK_EN:
- When defined, while in SHOW with blink phase 0, text-band pixels (aligned rom_y <= 20) are treated as transparent, so rgb_out = bg_rgb.
- When undefined, no blink logic is compiled, the text band is always shown, and state timing is otherwise identical.

Verification
REQ-036 Reset: rst high for 2 clocks -> state_o=0 and rgb_out=0; with bg_rgb=16'h1234 and video_on=1, rgb_out=16'h1234 three clocks later.
REQ-037 Latency and mapping: state SHOW, hcount=ORIGIN_X+2, vcount=ORIGIN_Y+4 with SCALE_LOG2=1 -> rom_x=1 and rom_y=2 after 1 clock; rom_rgb=16'h07E0 -> rgb_out=16'h07E0 exactly 3 clocks after the input.
REQ-038 Transparency and edges:
- rom_rgb=0 inside the window -> rgb_out=bg_rgb.
- hcount=ORIGIN_X+128 -> outside the window -> rgb_out=bg_rgb.
- video_on=0 -> rgb_out=0.
REQ-039 Sequencing:
- win_evt -> state_o=1.
- After 180 frame_ticks, state_o=2.
- A further win_evt leaves the state unchanged.
- restart -> state_o=0.
REQ-040 Simultaneous events: win_evt and restart in the same cycle while in IDLE -> state_o stays 0.
REQ-041 Blink (WIN_SCREEN_BLINK_EN defined): after 15 frame_ticks in SHOW, a text pixel (rom_y=5, rom_rgb=16'h07E0) -> rgb_out=bg_rgb; after 30 frame_ticks -> rgb_out=16'h07E0.
